entity_move_animator: RTL and testbench
=======================================

Name: entity_move_animator

Overview:
- Animates and commits one player ("cowboy") move on the 10x10 board held in the object memory (OM), optionally pushing a box.
- The game controller supplies the cowboy position, the target cell, the cell types and the direction, then raises process_move once per displayed frame.
- The block writes the per-frame OM updates and returns a frame-ready handshake. On the last frame it also returns the new cowboy position and a done flag.

Parameters:
- STEPS, 4, frames per move (2..63); frames 1..STEPS-1 animate, frame STEPS commits.
- ROW, 10, board width used in address = row*ROW+col.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- address_write  out  7  OM write address
- data_write  out  11  OM write data: [10:8] cell type, [7:2] animation offset, [1:0] direction
- wren  out  1  OM write enable
- cowboy_row_out  out  7  new cowboy row, valid with move_done
- cowboy_col_out  out  7  new cowboy column, valid with move_done
- new_state_ready  out  1  one-cycle pulse: this frame's writes are complete
- move_done  out  1  high together with new_state_ready on the final frame only
- cowboy_row, cowboy_col  in  7 each  current cowboy cell C
- pos_cowboy  in  11  [10:8] type of C (3 = cowboy on floor, 4 = cowboy on goal); [1:0] direction
- other_row, other_col  in  7 each  destination cell D
- pos_other  in  11  [10:8] type of D (0 floor, 1 goal, 5 box on floor, 6 box on goal)
- only_moving_cowboy  in  1  1 = plain step, 0 = box push
- process_move  in  1  level request for the next frame
- field_type_after  in  3  type (0/1) of box destination B, used for push only

Behaviour:
- Direction code pos_cowboy[1:0]: 00 left, 01 right, 10 up, 11 down.
- B = D shifted one cell in that direction.
- Addresses = row*ROW+col, truncated to 7 bits. Bounds are not checked; the controller guarantees legal moves.
- States: IDLE, WRITE, READY, WAITLOW.
- Reset: all outputs 0, frame counter k=0, state IDLE.
- IDLE: when process_move=1, set k<=k+1, latch all inputs and enter WRITE on the next cycle.
- WRITE: issues one write per cycle with wren=1, in a fixed order.
  - Animation frame (k<STEPS):
    - C written with {type C, k, dir}.
    - For a push, D written with {type D, k, dir}.
  - Final frame (k==STEPS), in this order:
    - C <= {C-3, 0, 00} (3→0, 4→1).
    - D <= {cowboy type, 0, 00}. Cowboy type = 3 if the underlying field is floor, 4 if goal. Underlying field is D type for a step, or 0 for a type-5 box / 1 for a type-6 box when pushing.
    - For a push only, B <= {field_type_after+5, 0, 00}.
    - Address 100 <= other_row.
    - Address 101 <= other_col.
- READY: one cycle with wren=0 and new_state_ready=1.
  - If final: move_done=1, cowboy_row_out=other_row, cowboy_col_out=other_col, k<=0.
- WAITLOW: wait for process_move=0, then go to IDLE. A process_move still high on the same frame never retriggers.
- Outputs:
  - cowboy_row_out/col_out hold their value until the next final frame.
  - address_write/data_write are don't-care when wren=0.
- Inputs are sampled only at the IDLE→WRITE transition. Changes during WRITE are ignored.
- Asserting rst_n low mid-move aborts immediately: wren=0, k=0, IDLE.
- The star counter at address 102 is never written.

Test Plan:
- STEPS=4, C=(5,5) type 3, D=(5,6) type 0, dir 01, step. Four frames:
  - Frames 1–3: single write, addr 55, data {3,k,01}, then a ready pulse with move_done=0.
  - Frame 4: writes 55←{0,0,0}, 56←{3,0,0}, 100←5, 101←6, then ready pulse with move_done=1 and out=(5,6).
- Push up: C=(4,2) type 4, D=(3,2) type 6, field_type_after=0.
  - Final writes 42←{1}, 32←{4}, 22←{5}, 100←3, 101←2.
  - Animation frames write both 42 and 32 with offset k and dir 10.
- process_move held high for 10 cycles → exactly one frame is processed and one new_state_ready pulse is issued.
- rst_n pulsed low during final-frame WRITE → wren drops immediately. The next process_move restarts at k=1.
- Left step with dir 00 from (0,1) to (0,0) → addresses 1 and 0; write 1←{0,…} on commit.

Source files
------------

// File: rtl/entity_move_animator.sv
// Animates one cowboy move on the 10x10 object memory, optionally pushing a box.
// Each process_move frame yields a burst of OM writes followed by a one-cycle ready pulse.
module entity_move_animator #(
  parameter int unsigned STEPS = 4,
  parameter int unsigned ROW   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [6:0]  address_write,
  output logic [10:0] data_write,
  output logic        wren,
  output logic [6:0]  cowboy_row_out,
  output logic [6:0]  cowboy_col_out,
  output logic        new_state_ready,
  output logic        move_done,
  input  logic [6:0]  cowboy_row,
  input  logic [6:0]  cowboy_col,
  input  logic [10:0] pos_cowboy,
  input  logic [6:0]  other_row,
  input  logic [6:0]  other_col,
  input  logic [10:0] pos_other,
  input  logic        only_moving_cowboy,
  input  logic        process_move,
  input  logic [2:0]  field_type_after
);

  localparam logic [5:0] StepsK  = 6'(STEPS);
  localparam logic [6:0] AddrRow = 7'd100;
  localparam logic [6:0] AddrCol = 7'd101;

  typedef enum logic [1:0] {StIdle, StWrite, StReady, StWaitLow} state_e;

  state_e     state_q;
  logic [5:0] k_q;
  logic [2:0] idx_q;
  logic       final_q;
  logic       push_q;
  logic [6:0] c_addr_q, d_addr_q, b_addr_q;
  logic [2:0] c_type_q, d_type_q, fta_q;
  logic [1:0] dir_q;
  logic [6:0] orow_q, ocol_q;

  logic [6:0]  b_row, b_col;
  logic [6:0]  wr_addr;
  logic [10:0] wr_data;
  logic        wr_last;
  logic [2:0]  slot;
  logic [2:0]  under_type;
  logic [2:0]  cow_type;

  logic unused_inputs;
  assign unused_inputs = ^{pos_cowboy[7:2], pos_other[7:0]};

  function automatic logic [6:0] cell_addr(input logic [6:0] r, input logic [6:0] c);
    logic [31:0] a;
    a = 32'(r) * ROW + 32'(c);
    return a[6:0];
  endfunction

  // Box destination: the destination cell shifted once more along the move direction.
  always_comb begin
    b_row = other_row;
    b_col = other_col;
    unique case (pos_cowboy[1:0])
      2'b00: b_col = other_col - 7'd1;
      2'b01: b_col = other_col + 7'd1;
      2'b10: b_row = other_row - 7'd1;
      2'b11: b_row = other_row + 7'd1;
      default: ;
    endcase
  end

  always_comb begin
    under_type = push_q ? {2'b00, d_type_q == 3'd6} : d_type_q;
    cow_type   = 3'd3 + under_type;
    // A plain step has no box write, so its commit slots skip index 2.
    slot = (!push_q && idx_q >= 3'd2) ? 3'(idx_q + 3'd1) : idx_q;
    wr_addr = '0;
    wr_data = '0;
    wr_last = 1'b0;
    if (!final_q) begin
      if (idx_q == 3'd0) begin
        wr_addr = c_addr_q;
        wr_data = {c_type_q, k_q, dir_q};
      end else begin
        wr_addr = d_addr_q;
        wr_data = {d_type_q, k_q, dir_q};
      end
      wr_last = push_q ? (idx_q == 3'd1) : (idx_q == 3'd0);
    end else begin
      unique case (slot)
        3'd0: begin
          wr_addr = c_addr_q;
          wr_data = {c_type_q - 3'd3, 8'd0};
        end
        3'd1: begin
          wr_addr = d_addr_q;
          wr_data = {cow_type, 8'd0};
        end
        3'd2: begin
          wr_addr = b_addr_q;
          wr_data = {fta_q + 3'd5, 8'd0};
        end
        3'd3: begin
          wr_addr = AddrRow;
          wr_data = {4'd0, orow_q};
        end
        default: begin
          wr_addr = AddrCol;
          wr_data = {4'd0, ocol_q};
        end
      endcase
      wr_last = push_q ? (idx_q == 3'd4) : (idx_q == 3'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      k_q             <= '0;
      idx_q           <= '0;
      final_q         <= 1'b0;
      push_q          <= 1'b0;
      c_addr_q        <= '0;
      d_addr_q        <= '0;
      b_addr_q        <= '0;
      c_type_q        <= '0;
      d_type_q        <= '0;
      fta_q           <= '0;
      dir_q           <= '0;
      orow_q          <= '0;
      ocol_q          <= '0;
      address_write   <= '0;
      data_write      <= '0;
      wren            <= 1'b0;
      cowboy_row_out  <= '0;
      cowboy_col_out  <= '0;
      new_state_ready <= 1'b0;
      move_done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wren            <= 1'b0;
          new_state_ready <= 1'b0;
          move_done       <= 1'b0;
          if (process_move) begin
            k_q      <= k_q + 6'd1;
            final_q  <= (k_q + 6'd1) == StepsK;
            idx_q    <= '0;
            push_q   <= !only_moving_cowboy;
            c_addr_q <= cell_addr(cowboy_row, cowboy_col);
            d_addr_q <= cell_addr(other_row, other_col);
            b_addr_q <= cell_addr(b_row, b_col);
            c_type_q <= pos_cowboy[10:8];
            d_type_q <= pos_other[10:8];
            dir_q    <= pos_cowboy[1:0];
            fta_q    <= field_type_after;
            orow_q   <= other_row;
            ocol_q   <= other_col;
            state_q  <= StWrite;
          end
        end
        StWrite: begin
          wren          <= 1'b1;
          address_write <= wr_addr;
          data_write    <= wr_data;
          if (wr_last) begin
            state_q <= StReady;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StReady: begin
          wren            <= 1'b0;
          new_state_ready <= 1'b1;
          move_done       <= final_q;
          if (final_q) begin
            cowboy_row_out <= orow_q;
            cowboy_col_out <= ocol_q;
            k_q            <= '0;
          end
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          new_state_ready <= 1'b0;
          move_done       <= 1'b0;
          if (!process_move) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_move_animator.sv
// Scoreboard bench: stimulus queues hand-computed writes and ready pulses, a monitor
// pops and compares them whenever the animator presents a write or a ready pulse.
module tb_entity_move_animator;

  logic        clk;
  logic        rst_n;
  logic [6:0]  address_write;
  logic [10:0] data_write;
  logic        wren;
  logic [6:0]  cowboy_row_out;
  logic [6:0]  cowboy_col_out;
  logic        new_state_ready;
  logic        move_done;
  logic [6:0]  cowboy_row;
  logic [6:0]  cowboy_col;
  logic [10:0] pos_cowboy;
  logic [6:0]  other_row;
  logic [6:0]  other_col;
  logic [10:0] pos_other;
  logic        only_moving_cowboy;
  logic        process_move;
  logic [2:0]  field_type_after;

  entity_move_animator #(.STEPS(4), .ROW(10)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .address_write      (address_write),
    .data_write         (data_write),
    .wren               (wren),
    .cowboy_row_out     (cowboy_row_out),
    .cowboy_col_out     (cowboy_col_out),
    .new_state_ready    (new_state_ready),
    .move_done          (move_done),
    .cowboy_row         (cowboy_row),
    .cowboy_col         (cowboy_col),
    .pos_cowboy         (pos_cowboy),
    .other_row          (other_row),
    .other_col          (other_col),
    .pos_other          (pos_other),
    .only_moving_cowboy (only_moving_cowboy),
    .process_move       (process_move),
    .field_type_after   (field_type_after)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] exp_wr[$];
  logic [14:0] exp_rdy[$];
  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wren) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr %0d data 0x%0h, none required",
                   address_write, data_write);
        end else begin
          chk("write", {14'd0, address_write, data_write}, {14'd0, exp_wr.pop_front()});
        end
      end
      if (new_state_ready) begin
        rdy_cnt++;
        if (exp_rdy.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready got 1 required 0");
        end else begin
          chk("ready", {17'd0, move_done, cowboy_row_out, cowboy_col_out},
              {17'd0, exp_rdy.pop_front()});
        end
      end
    end
  end

  task automatic ew(input int a, input logic [10:0] d);
    exp_wr.push_back({7'(a), d});
  endtask

  task automatic er(input logic done, input int r, input int c);
    exp_rdy.push_back({done, 7'(r), 7'(c)});
  endtask

  task automatic set_move(input int cr, input int cc, input logic [10:0] pc, input int orr,
                          input int oc, input logic [10:0] po, input logic only,
                          input logic [2:0] fta);
    cowboy_row         = 7'(cr);
    cowboy_col         = 7'(cc);
    pos_cowboy         = pc;
    other_row          = 7'(orr);
    other_col          = 7'(oc);
    pos_other          = po;
    only_moving_cowboy = only;
    field_type_after   = fta;
  endtask

  // Hold process_move for at least 'hold' cycles; exactly one ready pulse must result.
  task automatic run_frame(input int hold);
    int start;
    start = rdy_cnt;
    process_move = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (rdy_cnt > start && i >= hold - 1) break;
    end
    chk("ready_pulse_count", 32'(rdy_cnt - start), 32'd1);
    process_move = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    process_move = 1'b0;
    set_move(0, 0, 11'd0, 0, 0, 11'd0, 1'b1, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wren", {31'd0, wren}, 32'd0);
    chk("reset_ready", {31'd0, new_state_ready}, 32'd0);
    chk("reset_done", {31'd0, move_done}, 32'd0);
    chk("reset_row_out", {25'd0, cowboy_row_out}, 32'd0);
    chk("reset_col_out", {25'd0, cowboy_col_out}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Right step (5,5)->(5,6); first frame holds process_move for 10 cycles.
    set_move(5, 5, {3'd3, 6'd0, 2'b01}, 5, 6, {3'd0, 8'd0}, 1'b1, 3'd0);
    for (int k = 1; k <= 3; k++) begin
      ew(55, {3'd3, 6'(k), 2'b01});
      er(1'b0, 0, 0);
      run_frame(k == 1 ? 10 : 1);
    end
    ew(55, 11'h000);
    ew(56, 11'h300);
    ew(100, 11'd5);
    ew(101, 11'd6);
    er(1'b1, 5, 6);
    run_frame(1);

    // Push up: cowboy on goal (4,2), box on goal (3,2), box lands on floor (2,2).
    set_move(4, 2, {3'd4, 6'd0, 2'b10}, 3, 2, {3'd6, 8'd0}, 1'b0, 3'd0);
    for (int k = 1; k <= 3; k++) begin
      ew(42, {3'd4, 6'(k), 2'b10});
      ew(32, {3'd6, 6'(k), 2'b10});
      er(1'b0, 5, 6);
      run_frame(1);
    end
    ew(42, 11'h100);
    ew(32, 11'h400);
    ew(22, 11'h500);
    ew(100, 11'd3);
    ew(101, 11'd2);
    er(1'b1, 3, 2);
    run_frame(1);

    // Same push again, aborted by reset during the commit frame.
    for (int k = 1; k <= 3; k++) begin
      ew(42, {3'd4, 6'(k), 2'b10});
      ew(32, {3'd6, 6'(k), 2'b10});
      er(1'b0, 3, 2);
      run_frame(1);
    end
    ew(42, 11'h100);
    process_move = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wren) break;
    end
    chk("abort_saw_write", {31'd0, wren}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_wren", {31'd0, wren}, 32'd0);
    chk("abort_row_out", {25'd0, cowboy_row_out}, 32'd0);
    process_move = 1'b0;
    exp_wr.delete();
    exp_rdy.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Left step (0,1)->(0,0) onto a goal; must restart at k=1.
    set_move(0, 1, {3'd3, 6'd0, 2'b00}, 0, 0, {3'd1, 8'd0}, 1'b1, 3'd0);
    for (int k = 1; k <= 3; k++) begin
      ew(1, {3'd3, 6'(k), 2'b00});
      er(1'b0, 0, 0);
      run_frame(1);
    end
    ew(1, 11'h000);
    ew(0, 11'h400);
    ew(100, 11'd0);
    ew(101, 11'd0);
    er(1'b1, 0, 0);
    run_frame(1);

    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    chk("readies_left", 32'(exp_rdy.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
